// File: rtl/pc_gen_multi_pkg.sv
// Shared types and constants for the multi-source fetch PC generator.
// FSM encoding, reset/stall/chip-enable levels and a select-width helper.
package pc_gen_multi_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HOLD = 2'd2
    } pc_state_t;

    localparam logic RSTN_ENABLE   = 1'b0;
    localparam logic CHIPS_ENABLE  = 1'b1;
    localparam logic CHIPS_DISABLE = 1'b0;
    localparam logic STOP          = 1'b1;

    // Width of a channel index; at least one bit so a single channel still has a port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_gen_multi_arb.sv
// Fixed-priority redirect arbiter: highest-index valid channel wins.
// Latency: combinational. Backpressure: none, pure function of inputs.
// Reports any-valid, winning index and winning target.
module pc_gen_multi_arb
    import pc_gen_multi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int NUM_REDIR = 2,
    parameter int SEL_W     = sel_width(NUM_REDIR)
) (
    input  logic [NUM_REDIR-1:0]        redir_valid_i,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_target_i,
    output logic                        any,
    output logic [SEL_W-1:0]            sel,
    output logic [ADDR_W-1:0]           tgt
);

    // Ascending scan so the oldest (highest-index) valid stage overrides younger ones.
    always_comb begin
        any = 1'b0;
        sel = '0;
        tgt = redir_target_i[ADDR_W-1:0];
        for (int k = 0; k < NUM_REDIR; k++) begin
            if (redir_valid_i[k]) begin
                any = 1'b1;
                sel = SEL_W'(k);
                tgt = redir_target_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/pc_gen_multi.sv
// IF-stage program counter with prioritised multi-stage redirects; holds a redirect across a stall.
// Latency: redirect/step visible on pc_o one edge later. Backpressure: stall_i freezes pc_o, parks redirect.
// Optional macro PC_MISALIGN_EN: misaligned applied targets trap to TRAP_VEC and pulse misalign_o.
module pc_gen_multi
    import pc_gen_multi_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                NUM_REDIR = 2,
    parameter int                PC_STEP   = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(32'h0000_0100)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall_i,
    input  logic [NUM_REDIR-1:0]        redir_valid_i,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_target_i,
    output logic [ADDR_W-1:0]           pc_o,
    output logic                        ce_o,
    output logic                        pend_o,
    output logic                        misalign_o
);

    localparam int SEL_W = sel_width(NUM_REDIR);

    pc_state_t          state_q, state_nxt;
    logic [ADDR_W-1:0]  pc_q, pc_nxt;
    logic [ADDR_W-1:0]  pend_tgt_q, pend_tgt_nxt;
    logic [SEL_W-1:0]   pend_src_q, pend_src_nxt;
    logic               load;
    logic [ADDR_W-1:0]  load_tgt;

    logic               arb_any;
    logic [SEL_W-1:0]   arb_sel;
    logic [ADDR_W-1:0]  arb_tgt;
    logic               stalled;

    assign stalled = (stall_i == STOP);

    pc_gen_multi_arb #(
        .ADDR_W    (ADDR_W),
        .NUM_REDIR (NUM_REDIR),
        .SEL_W     (SEL_W)
    ) u_arb (
        .redir_valid_i  (redir_valid_i),
        .redir_target_i (redir_target_i),
        .any            (arb_any),
        .sel            (arb_sel),
        .tgt            (arb_tgt)
    );

`ifdef PC_MISALIGN_EN
    logic mis_q, mis_nxt;
`endif

    always_comb begin
        state_nxt    = state_q;
        pc_nxt       = pc_q;
        pend_tgt_nxt = pend_tgt_q;
        pend_src_nxt = pend_src_q;
        load         = 1'b0;
        load_tgt     = pend_tgt_q;
        case (state_q)
            PC_BOOT: state_nxt = PC_RUN;
            PC_RUN: begin
                if (arb_any) begin
                    if (!stalled) begin
                        load     = 1'b1;
                        load_tgt = arb_tgt;
                    end else begin
                        pend_tgt_nxt = arb_tgt;
                        pend_src_nxt = arb_sel;
                        state_nxt    = PC_HOLD;
                    end
                end else if (!stalled) begin
                    pc_nxt = pc_q + ADDR_W'(PC_STEP);
                end
            end
            PC_HOLD: begin
                // A younger stage than the parked one is on the wrong path and is dropped.
                if (arb_any && (arb_sel >= pend_src_q)) begin
                    if (!stalled) begin
                        load      = 1'b1;
                        load_tgt  = arb_tgt;
                        state_nxt = PC_RUN;
                    end else begin
                        pend_tgt_nxt = arb_tgt;
                        pend_src_nxt = arb_sel;
                    end
                end else if (!stalled) begin
                    load      = 1'b1;
                    load_tgt  = pend_tgt_q;
                    state_nxt = PC_RUN;
                end
            end
            default: state_nxt = PC_BOOT;
        endcase
        if (load) begin
            pc_nxt = load_tgt;
        end
`ifdef PC_MISALIGN_EN
        mis_nxt = 1'b0;
        if (load && (load_tgt[1:0] != 2'b00)) begin
            pc_nxt  = TRAP_VEC;
            mis_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst == RSTN_ENABLE) begin
            state_q    <= PC_BOOT;
            pc_q       <= RESET_VEC;
            pend_tgt_q <= '0;
            pend_src_q <= '0;
        end else begin
            state_q    <= state_nxt;
            pc_q       <= pc_nxt;
            pend_tgt_q <= pend_tgt_nxt;
            pend_src_q <= pend_src_nxt;
        end
    end

`ifdef PC_MISALIGN_EN
    always_ff @(posedge clk) begin
        if (rst == RSTN_ENABLE) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_nxt;
        end
    end
    assign misalign_o = mis_q;
`else
    assign misalign_o = 1'b0;
`endif

    assign pc_o   = pc_q;
    assign ce_o   = (state_q != PC_BOOT) ? CHIPS_ENABLE : CHIPS_DISABLE;
    assign pend_o = (state_q == PC_HOLD);

endmodule
